// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port owner, default address width.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 20;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e;
   typedef enum logic {ARB_PORT_D, ARB_PORT_I} arb_port_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation guard for the fetch port: counts fetch losses to the data port, saturating at
// STARVE_LIMIT; at the limit the fetch port wins the next conflict.
module mem_arb_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_async,
   input  logic conflict_i,
   input  logic grant_i_i,
   output logic i_priority_o
);

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_i_i) begin
         cnt_d = '0;
      end else if (conflict_i && (cnt_q < Limit)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign i_priority_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the data stage (D, priority) and instruction fetch (I).
// Optional counters enabled by defining MEM_PORT_ARB_STATS_EN.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = mem_port_arbiter_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_async,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_access_active,
   output logic              mem_write_enable,
   output logic [31:0]       mem_write_value,
   input  logic [31:0]       mem_read_value,
   input  logic              mem_ready
`ifdef MEM_PORT_ARB_STATS_EN
   ,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_i_wait
`endif
);

   import mem_port_arbiter_pkg::*;

   arb_state_e        state_q, state_d;
   arb_port_e         owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic              grant_d, grant_i, conflict, i_priority, in_access;

   assign conflict = (state_q == ARB_IDLE) && d_req && i_req;

   mem_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk          (clk),
      .rst_async    (rst_async),
      .conflict_i   (conflict),
      .grant_i_i    (grant_i),
      .i_priority_o (i_priority)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      d_rdata_d = d_rdata_q;
      i_rdata_d = i_rdata_q;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            grant_i = i_req && (!d_req || i_priority);
            grant_d = d_req && !grant_i;
            if (grant_d) begin
               owner_d = ARB_PORT_D;
               addr_d  = d_addr;
               we_d    = d_we;
               wdata_d = d_wdata;
               state_d = ARB_ACCESS;
            end else if (grant_i) begin
               owner_d = ARB_PORT_I;
               addr_d  = i_addr;
               we_d    = 1'b0;
               wdata_d = '0;
               state_d = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (mem_ready) begin
               if (owner_q == ARB_PORT_D) begin
                  d_rdata_d = mem_read_value;
               end else begin
                  i_rdata_d = mem_read_value;
               end
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_q   <= ARB_IDLE;
         owner_q   <= ARB_PORT_D;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         d_rdata_q <= '0;
         i_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         d_rdata_q <= d_rdata_d;
         i_rdata_q <= i_rdata_d;
      end
   end

   // Memory side is decoded purely from registers, so async reset drops it at once.
   assign in_access         = (state_q == ARB_ACCESS);
   assign mem_access_active = in_access;
   assign mem_address       = in_access ? addr_q : '0;
   assign mem_write_enable  = in_access && we_q;
   assign mem_write_value   = in_access ? wdata_q : '0;
   assign d_done            = (state_q == ARB_RESP) && (owner_q == ARB_PORT_D);
   assign i_done            = (state_q == ARB_RESP) && (owner_q == ARB_PORT_I);
   assign d_rdata           = d_rdata_q;
   assign i_rdata           = i_rdata_q;

`ifdef MEM_PORT_ARB_STATS_EN
   logic [15:0] conf_q, conf_d, iwait_q, iwait_d;

   always_comb begin
      conf_d  = conf_q;
      iwait_d = iwait_q;
      if (conflict && (conf_q != 16'hFFFF)) begin
         conf_d = conf_q + 16'd1;
      end
      if (i_req && ((state_q == ARB_IDLE) || (owner_q != ARB_PORT_I)) &&
          (iwait_q != 16'hFFFF)) begin
         iwait_d = iwait_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         conf_q  <= '0;
         iwait_q <= '0;
      end else begin
         conf_q  <= conf_d;
         iwait_q <= iwait_d;
      end
   end

   assign stat_conflicts = conf_q;
   assign stat_i_wait    = iwait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store with waits, fetch, conflict order, reset.
// Counter checks are compiled in when MEM_PORT_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_async = 1'b1;
   logic        d_req = 1'b0, d_we = 1'b0, i_req = 1'b0, mem_ready = 1'b0;
   logic [19:0] d_addr = '0, i_addr = '0;
   logic [31:0] d_wdata = '0, mem_read_value = '0;
   logic [31:0] d_rdata, i_rdata, mem_write_value;
   logic        d_done, i_done, mem_access_active, mem_write_enable;
   logic [19:0] mem_address;
`ifdef MEM_PORT_ARB_STATS_EN
   logic [15:0] stat_conflicts, stat_i_wait;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .STARVE_LIMIT (4),
      .ADDR_W       (20)
   ) dut (
      .clk               (clk),
      .rst_async         (rst_async),
      .d_req             (d_req),
      .d_we              (d_we),
      .d_addr            (d_addr),
      .d_wdata           (d_wdata),
      .d_rdata           (d_rdata),
      .d_done            (d_done),
      .i_req             (i_req),
      .i_addr            (i_addr),
      .i_rdata           (i_rdata),
      .i_done            (i_done),
      .mem_address       (mem_address),
      .mem_access_active (mem_access_active),
      .mem_write_enable  (mem_write_enable),
      .mem_write_value   (mem_write_value),
      .mem_read_value    (mem_read_value),
      .mem_ready         (mem_ready)
`ifdef MEM_PORT_ARB_STATS_EN
      ,
      .stat_conflicts    (stat_conflicts),
      .stat_i_wait       (stat_i_wait)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_async = 1'b1;
      repeat (2) @(negedge clk);
      rst_async = 1'b0;
   endtask

   // One full arbitration with mem_ready=1, starting and ending in IDLE.
   task automatic run_grant(input string tag, input bit exp_i, input logic [19:0] exp_addr,
                            input logic [31:0] rv);
      mem_read_value = rv;
      tick();
      check_eq({tag, " active"}, 32'(mem_access_active), 32'd1);
      check_eq({tag, " addr"}, 32'(mem_address), 32'(exp_addr));
      tick();
      check_eq({tag, " done"}, {30'd0, i_done, d_done}, exp_i ? 32'd2 : 32'd1);
      check_eq({tag, " rdata"}, exp_i ? i_rdata : d_rdata, rv);
      tick();
   endtask

   initial begin
      do_reset();
      check_eq("rst active", 32'(mem_access_active), 32'd0);
      check_eq("rst addr", 32'(mem_address), 32'd0);
      check_eq("rst dones", {30'd0, i_done, d_done}, 32'd0);
      check_eq("rst d_rdata", d_rdata, 32'd0);
      check_eq("rst i_rdata", i_rdata, 32'd0);

      // Lone load
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00010;
      mem_ready = 1'b1; mem_read_value = 32'hDEADBEEF;
      tick();
      check_eq("load active", 32'(mem_access_active), 32'd1);
      check_eq("load addr", 32'(mem_address), 32'h00010);
      check_eq("load we", 32'(mem_write_enable), 32'd0);
      tick();
      check_eq("load done", 32'(d_done), 32'd1);
      check_eq("load rdata", d_rdata, 32'hDEADBEEF);
      check_eq("load mem idle in resp", 32'(mem_access_active), 32'd0);
      d_req = 1'b0;
      tick();
      check_eq("load done falls", 32'(d_done), 32'd0);
      check_eq("load rdata held", d_rdata, 32'hDEADBEEF);

      // Store with two wait states
      d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00020; d_wdata = 32'h12345678;
      mem_ready = 1'b0; mem_read_value = 32'h0BADF00D;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("store we c%0d", k), 32'(mem_write_enable), 32'd1);
         check_eq($sformatf("store val c%0d", k), mem_write_value, 32'h12345678);
         check_eq($sformatf("store dones c%0d", k), {30'd0, i_done, d_done}, 32'd0);
      end
      mem_ready = 1'b1;
      tick();
      check_eq("store d_done", 32'(d_done), 32'd1);
      check_eq("store i_done", 32'(i_done), 32'd0);
      check_eq("store we off in resp", 32'(mem_write_enable), 32'd0);
      d_req = 1'b0;
      tick();

      // Fetch alone, with a stale d_we=1 that must not leak
      i_req = 1'b1; i_addr = 20'h00100; d_we = 1'b1; mem_read_value = 32'hCAFEF00D;
      tick();
      check_eq("fetch addr", 32'(mem_address), 32'h00100);
      check_eq("fetch we", 32'(mem_write_enable), 32'd0);
      tick();
      check_eq("fetch dones", {30'd0, i_done, d_done}, 32'd2);
      check_eq("fetch rdata", i_rdata, 32'hCAFEF00D);
      check_eq("fetch d_rdata untouched", d_rdata, 32'h0BADF00D);
      i_req = 1'b0;
      tick();

      // Conflict: 4 D wins then I, repeated
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00AAA;
      i_req = 1'b1; i_addr = 20'h00BBB; mem_ready = 1'b1;
      for (int g = 0; g < 10; g++) begin
         if (g % 5 == 4) run_grant($sformatf("conf g%0d", g), 1'b1, 20'h00BBB, 32'h1000 + g);
         else            run_grant($sformatf("conf g%0d", g), 1'b0, 20'h00AAA, 32'h1000 + g);
      end
      d_req = 1'b0; i_req = 1'b0;
`ifdef MEM_PORT_ARB_STATS_EN
      check_eq("stat_conflicts", 32'(stat_conflicts), 32'd10);
      check_eq("stat_i_wait", 32'(stat_i_wait), 32'd26);
`endif

      // Reset mid-access after building up the starve count
      d_req = 1'b1; i_req = 1'b1;
      run_grant("pre g0", 1'b0, 20'h00AAA, 32'h2000);
      run_grant("pre g1", 1'b0, 20'h00AAA, 32'h2001);
      d_we = 1'b1; mem_ready = 1'b0;
      tick();
      check_eq("mid we before rst", 32'(mem_write_enable), 32'd1);
      #2 rst_async = 1'b1;
      #1;
      check_eq("mid rst active", 32'(mem_access_active), 32'd0);
      check_eq("mid rst we", 32'(mem_write_enable), 32'd0);
      d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
      @(negedge clk) rst_async = 1'b0;
      mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("post rst no done c%0d", k), {30'd0, i_done, d_done}, 32'd0);
      end
      d_req = 1'b1; i_req = 1'b1;
      for (int g = 0; g < 5; g++) begin
         if (g == 4) run_grant($sformatf("rst order g%0d", g), 1'b1, 20'h00BBB, 32'h3000 + g);
         else        run_grant($sformatf("rst order g%0d", g), 1'b0, 20'h00AAA, 32'h3000 + g);
      end
      d_req = 1'b0; i_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
